// File: rtl/medidor_bias_multi.sv
// Multi-channel GARO bias meter: counts ones per channel over a 2^resol window.
// Optional per-channel 0<->1 transition counts with MEDIDOR_BIAS_TRANSICIONES_EN.
module medidor_bias_multi #(
  parameter int N_CANALES = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           modo,
  input  logic [4:0]                     resol,
  input  logic [N_CANALES-1:0]           muestras,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic                           lock,
  output logic [N_CANALES*OUT_WIDTH-1:0] out
`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
  ,
  output logic [N_CANALES*OUT_WIDTH-1:0] out_trans
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    MIDE,
    ENTREGA,
    ESPERA
  } estado_t;

  localparam logic [OUT_WIDTH-1:0] UNO = 1;
  localparam logic [OUT_WIDTH-1:0] MAX = '1;

  estado_t estado;
  estado_t estado_sig;

  logic [31:0] ventana;
  logic [31:0] fin;
  logic [4:0]  resol_q;
  logic        modo_q;
  logic        ultimo;

  logic [N_CANALES-1:0][OUT_WIDTH-1:0] cuenta;
  logic [N_CANALES-1:0][OUT_WIDTH-1:0] cuenta_sig;

`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
  logic [N_CANALES-1:0][OUT_WIDTH-1:0] trans;
  logic [N_CANALES-1:0][OUT_WIDTH-1:0] trans_sig;
  logic [N_CANALES-1:0]                previa;
`endif

  assign fin    = (32'd1 << resol_q) - 32'd1;
  assign ultimo = (estado == MIDE) && (ventana == fin);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  // Abort on enable=0 overrides every other transition.
  always_comb begin
    estado_sig = estado;
    unique case (estado)
      IDLE:    if (enable) estado_sig = MIDE;
      MIDE:    if (ultimo) estado_sig = ENTREGA;
      ENTREGA: if (out_ready) estado_sig = modo_q ? MIDE : ESPERA;
      ESPERA:  estado_sig = ESPERA;
      default: estado_sig = IDLE;
    endcase
    if (!enable) estado_sig = IDLE;
  end

  // Next counts include the current sample and saturate at all ones.
  always_comb begin
    cuenta_sig = cuenta;
    for (int i = 0; i < N_CANALES; i++) begin
      if (muestras[i] && (cuenta[i] != MAX)) begin
        cuenta_sig[i] = cuenta[i] + UNO;
      end
    end
  end

`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
  // The first sample of a window has no predecessor to compare against.
  always_comb begin
    trans_sig = trans;
    for (int i = 0; i < N_CANALES; i++) begin
      if ((ventana != 32'd0) && (muestras[i] != previa[i])
          && (trans[i] != MAX)) begin
        trans_sig[i] = trans[i] + UNO;
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ventana   <= '0;
      resol_q   <= '0;
      modo_q    <= 1'b0;
      cuenta    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      lock      <= 1'b0;
    end else if (!enable) begin
      ventana   <= '0;
      cuenta    <= '0;
      out_valid <= 1'b0;
      lock      <= 1'b0;
    end else begin
      unique case (estado)
        IDLE: begin
          resol_q <= resol;
          modo_q  <= modo;
          ventana <= '0;
          cuenta  <= '0;
        end
        MIDE: begin
          ventana <= ventana + 32'd1;
          cuenta  <= cuenta_sig;
          if (ultimo) begin
            out       <= cuenta_sig;
            out_valid <= 1'b1;
            lock      <= 1'b1;
          end
        end
        ENTREGA: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ventana   <= '0;
            cuenta    <= '0;
          end
        end
        ESPERA: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trans     <= '0;
      previa    <= '0;
      out_trans <= '0;
    end else if (!enable) begin
      trans  <= '0;
      previa <= '0;
    end else begin
      unique case (estado)
        IDLE: begin
          trans <= '0;
        end
        MIDE: begin
          trans  <= trans_sig;
          previa <= muestras;
          if (ultimo) out_trans <= trans_sig;
        end
        ENTREGA: begin
          if (out_ready) trans <= '0;
        end
        ESPERA: begin
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_medidor_bias_multi.sv
// Directed bench for medidor_bias_multi: 32-bit and 4-bit count instances.
// Transition checks run when MEDIDOR_BIAS_TRANSICIONES_EN is defined.
module tb_medidor_bias_multi;

  logic         clock;
  logic         reset_n;
  logic         enable;
  logic         modo;
  logic [4:0]   resol;
  logic [3:0]   muestras;
  logic         out_ready;
  logic         out_valid;
  logic         lock;
  logic [127:0] out;
  logic         s_valid;
  logic         s_lock;
  logic [15:0]  s_out;
`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
  logic [127:0] trans;
  logic [15:0]  s_trans;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n;

  medidor_bias_multi #(.N_CANALES(4), .OUT_WIDTH(32)) u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .modo(modo), .resol(resol), .muestras(muestras),
    .out_ready(out_ready), .out_valid(out_valid),
    .lock(lock), .out(out)
`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
    , .out_trans(trans)
`endif
  );

  medidor_bias_multi #(.N_CANALES(4), .OUT_WIDTH(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .modo(modo), .resol(resol), .muestras(muestras),
    .out_ready(out_ready), .out_valid(s_valid),
    .lock(s_lock), .out(s_out)
`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
    , .out_trans(s_trans)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic esperar(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!out_valid && cnt <= max);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; modo = 1'b0; resol = '0;
    muestras = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_lock", lock, 0);
    chk("rst_out", out, 0);
    reset_n = 1'b1;
    tick();

    // single shot, constant 0101
    resol = 5'd3; modo = 1'b0; muestras = 4'b0101;
    out_ready = 1'b1; enable = 1'b1;
    tick();
    esperar(20, n);
    chk("t1_latency", n, 8);
    chk("t1_out", out, {32'd0, 32'd8, 32'd0, 32'd8});
    chk("t1_out4", s_out, {4'd0, 4'd8, 4'd0, 4'd8});
    chk("t1_lock", lock, 1);
    tick();
    chk("t1_hs_valid", out_valid, 0);
    repeat (6) tick();
    chk("t1_esp_valid", out_valid, 0);
    chk("t1_esp_lock", lock, 1);
    chk("t1_esp_out", out, {32'd0, 32'd8, 32'd0, 32'd8});
    enable = 1'b0;
    tick();
    chk("t1_off_lock", lock, 0);
    chk("t1_off_out", out, {32'd0, 32'd8, 32'd0, 32'd8});

    // continuous with back-pressure
    modo = 1'b1; resol = 5'd2; out_ready = 1'b0; enable = 1'b1;
    tick();
    muestras = 4'b0001; tick();
    muestras = 4'b0011; tick();
    muestras = 4'b0111; tick();
    chk("t2_early", out_valid, 0);
    muestras = 4'b1111; tick();
    chk("t2_valid", out_valid, 1);
    chk("t2_out", out, {32'd1, 32'd2, 32'd3, 32'd4});
    modo = 1'b0; resol = 5'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_valid", out_valid, 1);
      chk("t2_stall_out", out, {32'd1, 32'd2, 32'd3, 32'd4});
    end
    out_ready = 1'b1; tick();
    chk("t2_hs_valid", out_valid, 0);
    chk("t2_hs_lock", lock, 1);
    out_ready = 1'b0;
    muestras = 4'b1000; tick();
    muestras = 4'b1000; tick();
    muestras = 4'b0000; tick();
    chk("t2_w2_early", out_valid, 0);
    muestras = 4'b0001; tick();
    chk("t2_w2_valid", out_valid, 1);
    chk("t2_w2_out", out, {32'd2, 32'd0, 32'd0, 32'd1});
    enable = 1'b0;
    tick();
    chk("t2_off_valid", out_valid, 0);
    chk("t2_off_out", out, {32'd2, 32'd0, 32'd0, 32'd1});

    // saturation of the 4-bit instance
    modo = 1'b0; resol = 5'd6; muestras = 4'b0001;
    out_ready = 1'b1; enable = 1'b1;
    tick();
    esperar(100, n);
    chk("t3_latency", n, 64);
    chk("t3_out32", out, {96'd0, 32'd64});
    chk("t3_valid4", s_valid, 1);
    chk("t3_out4", s_out, 16'h000F);
    tick();
    enable = 1'b0;
    tick();

    // abort mid-window keeps previous result
    resol = 5'd3; muestras = 4'b1111; out_ready = 1'b1; enable = 1'b1;
    tick();
    tick();
    tick();
    enable = 1'b0;
    tick();
    chk("t4_valid", out_valid, 0);
    chk("t4_lock", lock, 0);
    chk("t4_out", out, {96'd0, 32'd64});
    chk("t4_out4", s_out, 16'h000F);
    tick();
    chk("t4_idle_valid", out_valid, 0);

    // one-sample window, left pending in ENTREGA
    resol = 5'd0; muestras = 4'b0110; out_ready = 1'b0; enable = 1'b1;
    tick();
    tick();
    chk("t4_r0_valid", out_valid, 1);
    chk("t4_r0_out", out, {32'd0, 32'd1, 32'd1, 32'd0});
    chk("t4_r0_lock", lock, 1);

    // asynchronous reset while pending
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_out", out, 0);
    chk("t5_lock", lock, 0);
    chk("t5_out4", s_out, 0);
    enable = 1'b0;
    reset_n = 1'b1;
    tick();

    // alternating channel 1
    resol = 5'd3; modo = 1'b0; out_ready = 1'b1;
    muestras = 4'b0000; enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      muestras = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      tick();
    end
    chk("t6_valid", out_valid, 1);
    chk("t6_out", out, {32'd0, 32'd0, 32'd4, 32'd0});
`ifdef MEDIDOR_BIAS_TRANSICIONES_EN
    chk("t6_trans", trans, {32'd0, 32'd0, 32'd7, 32'd0});
    chk("t6_trans4", s_trans, {4'd0, 4'd0, 4'd7, 4'd0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
